alu_mul_ctrl: RTL

ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

---
 rtl/alu_mul_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_mul_ctrl.sv
// Shift-and-add multiplier controller that borrows a shared 16-bit ALU.
// One ADD cycle per set multiplier bit, one SHIFT cycle per multiplier bit
// position up to the highest set bit; carries and shifted-out multiplicand
// bits are folded into a sticky overflow flag so ovf reports exactly whether
// the true 32-bit product exceeds 16 bits.
module alu_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [15:0] mcand_reg;
  logic [15:0] mplr_reg;
  logic [15:0] acc_reg;
  logic        ovf_int_reg;
  logic [15:0] product_reg;
  logic        ovf_reg;
  logic        busy_reg;
  logic        done_reg;

  // Multiplier bits still to be consumed after the current SHIFT.
  logic        mplr_rest_nz;
  assign mplr_rest_nz = (mplr_reg[15:1] != 15'd0);

  // Drive the shared ALU from the current state; idle states present ADD 0+0.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = 16'd0;
    alu_b  = 16'd0;
    case (state_reg)
      ADD: begin
        alu_op = ALU_ADD;
        alu_a  = acc_reg;
        alu_b  = mcand_reg;
      end
      SHIFT: begin
        alu_op = ALU_SLL;
        alu_a  = mcand_reg;
        alu_b  = 16'd1;
      end
      default: begin
        alu_op = ALU_ADD;
        alu_a  = 16'd0;
        alu_b  = 16'd0;
      end
    endcase
  end

  // Control FSM with datapath registers; busy/done/product/ovf are loaded on
  // entry to their state so they are valid during that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= 16'd0;
      mplr_reg    <= 16'd0;
      acc_reg     <= 16'd0;
      ovf_int_reg <= 1'b0;
      product_reg <= 16'd0;
      ovf_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            mcand_reg   <= op_a;
            mplr_reg    <= op_b;
            acc_reg     <= 16'd0;
            ovf_int_reg <= 1'b0;
            if (op_b == 16'd0) begin
              // Nothing to accumulate: the product is trivially zero.
              state_reg   <= DONE;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              product_reg <= 16'd0;
              ovf_reg     <= 1'b0;
            end else begin
              state_reg <= op_b[0] ? ADD : SHIFT;
              busy_reg  <= 1'b1;
            end
          end
        end

        ADD: begin
          acc_reg <= alu_result;
          // A wrapped sum is smaller than the value it started from.
          if (alu_result < acc_reg) begin
            ovf_int_reg <= 1'b1;
          end
          state_reg <= SHIFT;
        end

        SHIFT: begin
          mcand_reg <= alu_result;
          mplr_reg  <= {1'b0, mplr_reg[15:1]};
          // A multiplicand bit falling off the top only matters if some
          // later multiplier bit would still add it in.
          if (mcand_reg[15] && mplr_rest_nz) begin
            ovf_int_reg <= 1'b1;
          end
          if (!mplr_rest_nz) begin
            // The last SHIFT leaves acc untouched and cannot raise ovf_int,
            // so the current values are already final.
            state_reg   <= DONE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            product_reg <= acc_reg;
            ovf_reg     <= ovf_int_reg;
          end else begin
            state_reg <= mplr_reg[1] ? ADD : SHIFT;
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;
  assign ovf     = ovf_reg;

endmodule
